// File: rtl/kd_tree_traverse_pipe.sv
// kd_tree_traverse_pipe: fully pipelined KD-tree traversal, one tree level per stage, leaf index out.
// Defining KD_QUERY_TAG_EN adds a TAG_WIDTH tag that travels with each query.
module kd_tree_traverse_pipe #(
    parameter int DEPTH     = 6,
    parameter int NUM_DIMS  = 5,
    parameter int DIM_WIDTH = 11,
    parameter int IDX_WIDTH = 3
`ifdef KD_QUERY_TAG_EN
    ,
    parameter int TAG_WIDTH = 8
`endif
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [DEPTH-1:0]               cfg_addr,
    input  logic [DIM_WIDTH+IDX_WIDTH-1:0] cfg_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_DIMS*DIM_WIDTH-1:0]  in_patch,
`ifdef KD_QUERY_TAG_EN
    input  logic [TAG_WIDTH-1:0]           in_tag,
    output logic [TAG_WIDTH-1:0]           out_tag,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DEPTH-1:0]               out_leaf
);
    localparam int NODES = 2**DEPTH - 1;
    localparam int PW    = NUM_DIMS * DIM_WIDTH;

    logic [IDX_WIDTH-1:0]        idx_q   [NODES];
    logic signed [DIM_WIDTH-1:0] med_q   [NODES];
    logic [DEPTH:1]              v_q;
    logic [DEPTH-1:0]            path_q  [1:DEPTH];
    logic [PW-1:0]               patch_q [1:DEPTH-1];
    logic [DEPTH-1:0]            path_d  [DEPTH];
    logic                        pipe_empty, advance, in_fire, cfg_fire;

    assign pipe_empty = ~|v_q;
    assign advance    = !v_q[DEPTH] || out_ready;
    assign cfg_ready  = pipe_empty;
    assign in_ready   = advance && !(cfg_valid && pipe_empty);
    assign in_fire    = in_valid && in_ready;
    assign cfg_fire   = cfg_valid && pipe_empty;
    assign out_valid  = v_q[DEPTH];
    assign out_leaf   = path_q[DEPTH];

    // Stage 0 decides the root straight from the input so the result lands after DEPTH registers.
    for (genvar g = 0; g < DEPTH; g++) begin : g_lvl
        logic [PW-1:0]               p;
        logic [DEPTH-1:0]            pa, na;
        logic [IDX_WIDTH-1:0]        ix;
        logic signed [DIM_WIDTH-1:0] sl;
        if (g == 0) begin : g_root
            assign p  = in_patch;
            assign pa = '0;
        end else begin : g_inner
            assign p  = patch_q[g];
            assign pa = path_q[g];
        end
        assign na = DEPTH'(2**g - 1) + pa;
        assign ix = idx_q[na];
        always_comb begin
            sl = '0;
            for (int d = 0; d < NUM_DIMS; d++)
                if (ix == IDX_WIDTH'(d)) sl = p[d*DIM_WIDTH +: DIM_WIDTH];
        end
        assign path_d[g] = {pa[DEPTH-2:0], !(sl < med_q[na])};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 1; i <= DEPTH; i++) path_q[i] <= '0;
            for (int i = 1; i < DEPTH; i++) patch_q[i] <= '0;
            for (int i = 0; i < NODES; i++) begin
                idx_q[i] <= '1;
                med_q[i] <= '0;
            end
        end else begin
            // The all-ones address has no node behind it and is silently dropped.
            if (cfg_fire && cfg_addr != {DEPTH{1'b1}}) begin
                idx_q[cfg_addr] <= cfg_data[IDX_WIDTH-1:0];
                med_q[cfg_addr] <= cfg_data[IDX_WIDTH +: DIM_WIDTH];
            end
            if (advance) begin
                v_q        <= {v_q[DEPTH-1:1], in_fire};
                path_q[1]  <= path_d[0];
                patch_q[1] <= in_patch;
                for (int i = 2; i <= DEPTH; i++) path_q[i] <= path_d[i-1];
                for (int i = 2; i < DEPTH; i++) patch_q[i] <= patch_q[i-1];
            end
        end
    end

`ifdef KD_QUERY_TAG_EN
    logic [TAG_WIDTH-1:0] tag_q [1:DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= DEPTH; i++) tag_q[i] <= '0;
        end else if (advance) begin
            tag_q[1] <= in_tag;
            for (int i = 2; i <= DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign out_tag = tag_q[DEPTH];
`endif
endmodule

// File: tb/tb_kd_tree_traverse_pipe.sv
// tb_kd_tree_traverse_pipe: scoreboard bench with a heap-walk reference model of the KD tree.
module tb_kd_tree_traverse_pipe;
    localparam int D = 6, N = 5, W = 11, I = 3, NODES = 63, PW = N * W;

    logic          clk = 0, rst_n = 0;
    logic          cfg_valid = 0, cfg_ready;
    logic [D-1:0]  cfg_addr = '0;
    logic [W+I-1:0] cfg_data = '0;
    logic          in_valid = 0, in_ready;
    logic [PW-1:0] in_patch = '0;
    logic          out_valid, out_ready = 1;
    logic [D-1:0]  out_leaf;

    kd_tree_traverse_pipe #(.DEPTH(D), .NUM_DIMS(N), .DIM_WIDTH(W), .IDX_WIDTH(I)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_patch(in_patch),
        .out_valid(out_valid), .out_ready(out_ready), .out_leaf(out_leaf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int m_med [NODES];
    int m_idx [NODES];
    int exp_q [$];
    int checks = 0, failures = 0;
    int out_cnt = 0, last_out_cyc = 0, last_acc_cyc = 0, cfg_acc_cyc = 0;
    bit done;

    function automatic int dim_of(input logic [PW-1:0] p, input int d);
        logic signed [W-1:0] x;
        x = p[d*W +: W];
        return int'(x);
    endfunction

    // Walk the heap from the root: children of n are 2n+1 (left) and 2n+2 (right).
    function automatic int model_leaf(input logic [PW-1:0] p);
        int n = 0;
        for (int l = 0; l < D; l++) begin
            int v;
            v = (m_idx[n] < N) ? dim_of(p, m_idx[n]) : 0;
            n = 2 * n + ((v >= m_med[n]) ? 2 : 1);
        end
        return n - NODES;
    endfunction

    function automatic logic [PW-1:0] pat(input int a0, a1, a2, a3, a4);
        return {W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    function automatic void reset_model();
        for (int i = 0; i < NODES; i++) begin
            m_med[i] = 0;
            m_idx[i] = 7;
        end
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic send(input logic [PW-1:0] p);
        bit acc = 0;
        in_valid = 1;
        in_patch = p;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model_leaf(p));
                last_acc_cyc = cyc;
                acc = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic cfg_write(input int addr, input int med, input int idx);
        bit acc = 0;
        cfg_valid = 1;
        cfg_addr  = D'(addr);
        cfg_data  = {W'(med), I'(idx)};
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (cfg_ready) begin
                if (addr < NODES) begin
                    m_med[addr] = med;
                    m_idx[addr] = idx;
                end
                cfg_acc_cyc = cyc;
                acc = 1;
            end
            @(posedge clk); #1;
        end
        cfg_valid = 0;
        if (!acc) chk("cfg_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && exp_q.size() > 0; t++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", int'(out_leaf), -1);
            else chk("leaf", int'(out_leaf), exp_q.pop_front());
            out_cnt++;
            last_out_cyc = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, fa, acc0;
        reset_model();
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_leaf", int'(out_leaf), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        send(pat(5, 5, 5, 5, 5));
        drain();
        chk("latency", last_out_cyc - last_acc_cyc, 6);

        cfg_write(0, 100, 2);
        send(pat(0, 0, 50, 0, 0));
        send(pat(0, 0, 100, 0, 0));
        send(pat(0, 0, -200, 0, 0));
        drain();

        for (int l = 0; l < D; l++)
            for (int p = 0; p < (1 << l); p++)
                cfg_write((1 << l) - 1 + p, p * (64 >> l) + (32 >> l), 0);
        c0 = out_cnt;
        fa = 0;
        for (int k = 0; k < 64; k++) begin
            send(pat(k, 0, 0, 0, 0));
            if (k == 0) fa = last_acc_cyc;
        end
        drain();
        chk("fullpath_count", out_cnt - c0, 64);
        chk("fullpath_in_rate", last_acc_cyc - fa, 63);
        chk("fullpath_out_rate", last_out_cyc - fa, 69);

        c0 = out_cnt;
        fork
            begin
                for (int k = 0; k < 10; k++) send(pat(k * 6, 1, 2, 3, 4));
            end
            begin
                for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
                @(posedge clk); #1;
                out_ready = 0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", int'(in_ready), 0);
                    chk("stall_out_valid", int'(out_valid), 1);
                    chk("stall_hold", int'(out_leaf), exp_q.size() > 0 ? exp_q[0] : -1);
                end
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        drain();
        chk("bp_count", out_cnt - c0, 10);

        send(pat(3, 0, 0, 0, 0));
        acc0 = last_acc_cyc;
        @(negedge clk);
        chk("cfg_blocked", int'(cfg_ready), 0);
        @(posedge clk); #1;
        cfg_write(5, 44, 0);
        chk("cfg_wait_drain", cfg_acc_cyc - acc0, 7);
        drain();

        fork
            cfg_write(0, -50, 1);
            send(pat(5, -10, 0, 0, 0));
        join
        chk("cfg_priority", last_acc_cyc - cfg_acc_cyc, 1);
        drain();

        cfg_write(63, 0, 0);
        send(pat(-5, -100, 0, 0, 0));
        send(pat(42, 0, 0, 0, 0));
        send(pat(20, -60, 0, 0, 0));
        drain();

        for (int i = 0; i < NODES; i++)
            cfg_write(i, int'($urandom_range(0, 2047)) - 1024, int'($urandom_range(0, 7)));
        c0 = out_cnt;
        done = 0;
        fork
            begin
                for (int k = 0; k < 150; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(PW'({$urandom(), $urandom()}));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1;
            end
        join
        drain();
        chk("rand_count", out_cnt - c0, 150);

        for (int k = 0; k < 9; k++) send(pat(k, 0, 0, 0, 0));
        chk("pre_rst_valid", int'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_leaf", int'(out_leaf), 0);
        exp_q.delete();
        reset_model();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_cfg_ready", int'(cfg_ready), 1);
        send(pat(1, 2, 3, 4, 5));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
